// File: rtl/rat_ckpt_ctrl_if.sv
// Rename/RAT/resolve signal bundle for the checkpoint-slot manager.
// The master drives rename groups, resolutions and flushes; the slave is the manager.
interface rat_ckpt_ctrl_if #(
    parameter int C_NUM = 2,
    parameter int ID_W  = $clog2(C_NUM)
);
    logic            ren_valid;
    logic            ren_br_1;
    logic            ren_br_2;
    logic            ren_ready;
    logic [ID_W-1:0] br_id_1;
    logic [ID_W-1:0] br_id_2;
    logic            take_checkpoint;
    logic            dual_branch;
    logic            instr_num;
    logic [ID_W-1:0] rat_current_id;
    logic            res_valid;
    logic [ID_W-1:0] res_id;
    logic            res_mispredict;
    logic            restore_rat;
    logic [ID_W-1:0] restore_id;
    logic            flush_all;
    logic [ID_W:0]   free_cnt;
    logic            ckpt_err;

    modport master (
        output ren_valid, ren_br_1, ren_br_2, rat_current_id,
               res_valid, res_id, res_mispredict, flush_all,
        input  ren_ready, br_id_1, br_id_2, take_checkpoint, dual_branch,
               instr_num, restore_rat, restore_id, free_cnt, ckpt_err
    );

    modport slave (
        input  ren_valid, ren_br_1, ren_br_2, rat_current_id,
               res_valid, res_id, res_mispredict, flush_all,
        output ren_ready, br_id_1, br_id_2, take_checkpoint, dual_branch,
               instr_num, restore_rat, restore_id, free_cnt, ckpt_err
    );
endinterface

// File: rtl/rat_ckpt_ctrl.sv
// Checkpoint-slot manager for the rename-stage RAT: allocates checkpoint IDs to
// branches, retires resolved slots in order and sequences RAT restore on mispredict.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | normal operation, rename may allocate
// S_RESTORE | restore_rat pulse cycle, rename held
// S_DRAIN   | one settling cycle after restore, rename held
module rat_ckpt_ctrl #(
    parameter int C_NUM = 2
) (
    input logic            clk,
    input logic            rst_n,
    rat_ckpt_ctrl_if.slave bus
);
    localparam int ID_W = $clog2(C_NUM);
    localparam logic [ID_W:0] FULL = (ID_W+1)'(C_NUM);

    typedef enum logic [1:0] {S_RUN, S_RESTORE, S_DRAIN} state_t;

    state_t          state;
    logic [ID_W-1:0] tail;
    logic [ID_W-1:0] head;
    logic [ID_W-1:0] restore_id_q;
    logic [ID_W:0]   count;
    logic [C_NUM-1:0] live;
    logic            restore_q;
    logic            err_q;

    logic [1:0]       need;
    logic [ID_W:0]    free;
    logic [ID_W:0]    add;
    logic [ID_W+1:0]  count_sum;
    logic             mispredict;
    logic             ready;
    logic             alloc;
    logic             retire;
    logic             res_live;
    logic             mp_live;
    logic             ok_resolve;
    logic             res_bad;
    logic [ID_W-1:0]  span;
    logic [C_NUM-1:0] live_n;

    always_comb begin
        need       = {1'b0, bus.ren_br_1} + {1'b0, bus.ren_br_2};
        free       = FULL - count;
        mispredict = bus.res_valid & bus.res_mispredict;
        ready      = (state == S_RUN) & ~bus.flush_all & ~mispredict
                     & (free >= (ID_W+1)'(need));
        alloc      = bus.ren_valid & ready & (need != 2'd0);
        retire     = (count != '0) & ~live[head];
        res_live   = live[bus.res_id];
        mp_live    = ~bus.flush_all & mispredict & res_live;
        ok_resolve = ~bus.flush_all & bus.res_valid & ~bus.res_mispredict & res_live;
        res_bad    = ~bus.flush_all & bus.res_valid & ~res_live;
        add        = alloc ? (ID_W+1)'(need) : '0;
        // retire only fires with count > 0, so the difference never underflows
        count_sum  = (ID_W+2)'(count) + (ID_W+2)'(add) - (ID_W+2)'(retire);
        // span == 0 with a live res_id means the ring is full: every slot is younger-or-equal
        span       = tail - bus.res_id;

        live_n = live;
        if (bus.flush_all) begin
            live_n = '0;
        end else begin
            if (ok_resolve) begin
                live_n[bus.res_id] = 1'b0;
            end
            if (mp_live) begin
                for (int i = 0; i < C_NUM; i++) begin
                    if ((span == '0) || (ID_W'(ID_W'(i) - bus.res_id) < span)) begin
                        live_n[i] = 1'b0;
                    end
                end
            end
            if (alloc) begin
                live_n[tail] = 1'b1;
                if (need == 2'd2) begin
                    live_n[tail + ID_W'(1)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RUN;
            tail         <= '0;
            head         <= '0;
            count        <= '0;
            live         <= '0;
            restore_q    <= 1'b0;
            restore_id_q <= '0;
            err_q        <= 1'b0;
        end else begin
            tail      <= tail + ID_W'(add);
            head      <= head + ID_W'(retire);
            count     <= count_sum[ID_W:0];
            live      <= live_n;
            restore_q <= mp_live;
            if (mp_live) begin
                restore_id_q <= bus.res_id;
            end
            err_q <= err_q | res_bad | (bus.rat_current_id != tail)
                     | (count_sum > (ID_W+2)'(FULL));

            if (bus.flush_all) begin
                state <= S_RUN;
            end else if (mp_live) begin
                state <= S_RESTORE;
            end else begin
                case (state)
                    S_RESTORE: state <= S_DRAIN;
                    S_DRAIN:   state <= S_RUN;
                    default:   state <= S_RUN;
                endcase
            end
        end
    end

    assign bus.ren_ready       = ready;
    assign bus.take_checkpoint = alloc;
    assign bus.dual_branch     = bus.ren_br_1 & bus.ren_br_2;
    assign bus.instr_num       = bus.ren_br_2 & ~bus.ren_br_1;
    assign bus.br_id_1         = tail;
    assign bus.br_id_2         = bus.ren_br_1 ? tail + ID_W'(1) : tail;
    assign bus.restore_rat     = restore_q;
    assign bus.restore_id      = restore_id_q;
    assign bus.free_cnt        = free;
    assign bus.ckpt_err        = err_q;
endmodule
